// File: rtl/mux8_rr_arbiter_if.sv
// Bus between the requesters and the round-robin mux arbiter.
// The master side presents the requests and the enable; the slave side (the
// arbiter) returns the registered grant, the mux select/enable and the busy flag.
interface mux8_rr_arbiter_if;
  logic       arb_en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       mux_en;
  logic       busy;

  modport master (
    output arb_en, req,
    input  gnt, sel, mux_en, busy
  );

  modport slave (
    input  arb_en, req,
    output gnt, sel, mux_en, busy
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that shares a single 8:1 mux between eight requesters.
// It drives the mux select {s2,s1,s0} and enable from registers only, holds a
// grant for at most MAX_HOLD cycles and then rotates to the next requester.
// The previous owner always comes last in the scan, which keeps access fair.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mux8_rr_arbiter_if.slave    bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q;
  logic [7:0]        gnt_q;
  logic [2:0]        sel_q;
  logic              mux_en_q;
  logic              busy_q;
  logic [HOLD_W-1:0] hold_q;
  logic [2:0]        last_q;

  logic [2:0]        searchBase;
  logic [2:0]        winIdx;
  logic              winValid;
  logic              retain;
  logic [2:0]        scanIdx;

  // Scan the request vector starting one past the base, wrapping 7->0; the
  // base itself is visited last. In GRANT the base is the current owner, since
  // any release makes the owner the new "last" before the next search.
  always_comb begin
    searchBase = (state_q == GRANT) ? sel_q : last_q;
    winIdx     = 3'd0;
    winValid   = 1'b0;
    scanIdx    = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      scanIdx = searchBase + 3'(k);
      if (!winValid && bus.req[scanIdx]) begin
        winValid = 1'b1;
        winIdx   = scanIdx;
      end
    end
  end

  // The owner keeps the mux while it still asks for it and its hold budget
  // is not spent; a MAX_HOLD of 1 makes this never true, so every cycle rescans.
  always_comb begin
    retain = bus.arb_en && bus.req[sel_q] && (hold_q < HoldLast);
  end

  // Arbitration FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      gnt_q    <= 8'h00;
      sel_q    <= 3'd0;
      mux_en_q <= 1'b0;
      busy_q   <= 1'b0;
      hold_q   <= '0;
      last_q   <= 3'd7;
    end else begin
      case (state_q)
        IDLE: begin
          hold_q <= '0;
          if (bus.arb_en && winValid) begin
            state_q  <= GRANT;
            gnt_q    <= 8'b1 << winIdx;
            sel_q    <= winIdx;
            mux_en_q <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= IDLE;
            gnt_q    <= 8'h00;
            sel_q    <= 3'd0;
            mux_en_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end

        GRANT: begin
          if (!bus.arb_en) begin
            state_q  <= IDLE;
            last_q   <= sel_q;
            gnt_q    <= 8'h00;
            sel_q    <= 3'd0;
            mux_en_q <= 1'b0;
            busy_q   <= 1'b0;
            hold_q   <= '0;
          end else if (retain) begin
            hold_q <= hold_q + 1'b1;
          end else begin
            last_q <= sel_q;
            hold_q <= '0;
            if (winValid) begin
              state_q  <= GRANT;
              gnt_q    <= 8'b1 << winIdx;
              sel_q    <= winIdx;
              mux_en_q <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              state_q  <= IDLE;
              gnt_q    <= 8'h00;
              sel_q    <= 3'd0;
              mux_en_q <= 1'b0;
              busy_q   <= 1'b0;
            end
          end
        end

        default: begin
          state_q  <= IDLE;
          gnt_q    <= 8'h00;
          sel_q    <= 3'd0;
          mux_en_q <= 1'b0;
          busy_q   <= 1'b0;
          hold_q   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.sel    = sel_q;
  assign bus.mux_en = mux_en_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: a directed vector table on a
// MAX_HOLD=4 instance, a full rotation under constant requests, and a
// MAX_HOLD=2 instance for short-hold wrap and lone-owner re-grant.
module tb_mux8_rr_arbiter;

  logic clk;
  logic rst;

  mux8_rr_arbiter_if if4 ();
  mux8_rr_arbiter_if if2 ();

  mux8_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if4)
  );

  mux8_rr_arbiter #(.MAX_HOLD(2), .HOLD_W(8)) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if2)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       mux;
    logic       busy;
  } vec_t;

  vec_t vecs[$];
  int   assertCount = 0;
  int   failCount   = 0;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive both instances identically at the falling edge, then step past the rising edge
  task automatic applyStimulus(input logic r, input logic en, input logic [7:0] rq);
    @(negedge clk);
    rst        = r;
    if4.arb_en = en;
    if4.req    = rq;
    if2.arb_en = en;
    if2.req    = rq;
    @(posedge clk);
    #1;
  endtask

  // Compare one instance's outputs with the expected values
  task automatic checkOutput(input string name,
                             input logic [7:0] aG, input logic [2:0] aS,
                             input logic aM, input logic aB,
                             input logic [7:0] eG, input logic [2:0] eS,
                             input logic eM, input logic eB);
    assertCount++;
    if ({aG, aS, aM, aB} !== {eG, eS, eM, eB}) begin
      failCount++;
      $display("[TB] FAIL %s: got gnt=%h sel=%0d mux_en=%b busy=%b, expected gnt=%h sel=%0d mux_en=%b busy=%b",
               name, aG, aS, aM, aB, eG, eS, eM, eB);
    end
  endtask

  initial begin
    rst        = 1'b1;
    if4.arb_en = 1'b0;
    if4.req    = 8'h00;
    if2.arb_en = 1'b0;
    if2.req    = 8'h00;

    // Directed vectors for the MAX_HOLD=4 instance: {rst, en, req, gnt, sel, mux_en, busy}
    vecs.push_back('{1'b0, 1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h03, 8'h01, 3'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h02, 8'h02, 3'd1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 8'h02, 8'h00, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h03, 8'h01, 3'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h82, 8'h02, 3'd1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h81, 8'h80, 3'd7, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 8'h04, 8'h00, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h05, 8'h01, 3'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h40, 8'h40, 3'd6, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'hC0, 8'h40, 3'd6, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 8'hC0, 8'h00, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'hC0, 8'h40, 3'd6, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'hC0, 8'h40, 3'd6, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'hC0, 8'h40, 3'd6, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'hC0, 8'h40, 3'd6, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'hC0, 8'h80, 3'd7, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h40, 8'h40, 3'd6, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});

    // Reset state, with requests present to show reset dominates
    applyStimulus(1'b1, 1'b1, 8'hFF);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    checkOutput("reset4", if4.gnt, if4.sel, if4.mux_en, if4.busy, 8'h00, 3'd0, 1'b0, 1'b0);
    checkOutput("reset2", if2.gnt, if2.sel, if2.mux_en, if2.busy, 8'h00, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00);

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].req);
      checkOutput($sformatf("vec%0d", i), if4.gnt, if4.sel, if4.mux_en, if4.busy,
                  vecs[i].gnt, vecs[i].sel, vecs[i].mux, vecs[i].busy);
    end

    // Full rotation with every requester asking: four cycles per owner, no gaps
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int n = 1; n <= 36; n++) begin
      int owner;
      owner = ((n - 1) / 4) % 8;
      applyStimulus(1'b0, 1'b1, 8'hFF);
      checkOutput($sformatf("rot%0d", n), if4.gnt, if4.sel, if4.mux_en, if4.busy,
                  8'b1 << owner, 3'(owner), 1'b1, 1'b1);
    end

    // Short hold: owners 0 and 7 alternate every two cycles
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int n = 1; n <= 8; n++) begin
      int owner;
      owner = (((n - 1) / 2) % 2 == 0) ? 0 : 7;
      applyStimulus(1'b0, 1'b1, 8'h81);
      checkOutput($sformatf("hold2_%0d", n), if2.gnt, if2.sel, if2.mux_en, if2.busy,
                  8'b1 << owner, 3'(owner), 1'b1, 1'b1);
    end

    // Lone requester is re-granted at hold expiry without dropping the mux
    for (int n = 1; n <= 5; n++) begin
      applyStimulus(1'b0, 1'b1, 8'h01);
      checkOutput($sformatf("regrant%0d", n), if2.gnt, if2.sel, if2.mux_en, if2.busy,
                  8'h01, 3'd0, 1'b1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
